// File: rtl/tea_iter_core.sv
// tea_iter_core: iterative TEA encrypt/decrypt engine, UNROLL rounds per clock,
// valid/ready block interface and a 128-bit key loaded as two 64-bit halves.
module tea_iter_core #(
  parameter int          ROUNDS = 32,
  parameter int          UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_wr_i,
  input  logic        key_hi_i,
  input  logic [63:0] key_in_i,
  output logic        key_ready_o,
  output logic        key_valid_o,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_mode_i,
  input  logic [63:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_data_o
);
  if (UNROLL < 1 || ROUNDS < 1 || ROUNDS % UNROLL != 0) begin : g_bad_params
    $error("tea_iter_core: ROUNDS must be >= 1 and a multiple of UNROLL");
  end
  localparam int          CW      = $clog2(ROUNDS + 1);
  localparam logic [31:0] SUM_DEC = DELTA * 32'(ROUNDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e         state_q, state_d;
  logic [127:0]   key_q, key_d, wkey_q, wkey_d;
  logic [1:0]     kset_q, kset_d;
  logic [31:0]    v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    r0, r1, rs;
  function automatic logic [31:0] f(input logic [31:0] x, ka, kb, s);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction
  assign key_ready_o = state_q == IDLE;
  assign key_valid_o = &kset_q;
  assign in_ready_o  = key_ready_o & key_valid_o;
  assign out_valid_o = state_q == DONE;
  assign out_data_o  = {v0_q, v1_q};
  // Rounds run on the key snapshot taken at accept, so IDLE key writes never touch a block in flight.
  always_comb begin
    r0 = v0_q;
    r1 = v1_q;
    rs = sum_q;
    for (int i = 0; i < UNROLL; i++) begin
      if (!mode_q) begin
        rs = rs + DELTA;
        r0 = r0 + f(r1, wkey_q[127:96], wkey_q[95:64], rs);
        r1 = r1 + f(r0, wkey_q[63:32], wkey_q[31:0], rs);
      end else begin
        r1 = r1 - f(r0, wkey_q[63:32], wkey_q[31:0], rs);
        r0 = r0 - f(r1, wkey_q[127:96], wkey_q[95:64], rs);
        rs = rs - DELTA;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    kset_d  = kset_q;
    wkey_d  = wkey_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    sum_d   = sum_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (key_wr_i) begin
          key_d = key_hi_i ? {key_in_i, key_q[63:0]} : {key_q[127:64], key_in_i};
          kset_d[key_hi_i] = 1'b1;
        end
        if (in_valid_i && in_ready_o) begin
          state_d      = RUN;
          wkey_d       = key_q;
          {v0_d, v1_d} = in_data_i;
          mode_d       = in_mode_i;
          cnt_d        = '0;
          sum_d        = in_mode_i ? SUM_DEC : 32'h0;
        end
      end
      RUN: begin
        v0_d    = r0;
        v1_d    = r1;
        sum_d   = rs;
        cnt_d   = cnt_q + CW'(UNROLL);
        state_d = cnt_d == CW'(ROUNDS) ? DONE : RUN;
      end
      DONE:    state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      kset_q  <= '0;
      wkey_q  <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      sum_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      kset_q  <= kset_d;
      wkey_q  <= wkey_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      sum_q   <= sum_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_tea_iter_core.sv
// tb_tea_iter_core: scoreboard bench for tea_iter_core at (32,1), (32,4) and (8,4).
module tb_tea_iter_core;
  localparam logic [31:0] DELTA = 32'h9E3779B9;
  localparam logic [63:0] T1    = 64'h41ea3a0a_94baa940;
  localparam logic [63:0] KX    = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] Y     = 64'hfedc_ba98_7654_3210;
  logic clk = 0, rst_n = 0, key_wr = 0, key_hi = 0, in_valid = 0, in_mode = 0, out_ready = 1;
  logic v4 = 0, v8 = 0;
  logic [63:0] key_in = '0, in_data = '0;
  logic key_ready, key_valid, in_ready, out_valid;
  logic [63:0] out_data;
  logic kr4, kv4, ir4, ov4, kr8, kv8, ir8, ov8;
  logic [63:0] od4, od8;
  logic [63:0] q[$], q4[$], q8[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  tea_iter_core dut (
    .clk(clk), .rst_n(rst_n), .key_wr_i(key_wr), .key_hi_i(key_hi), .key_in_i(key_in),
    .key_ready_o(key_ready), .key_valid_o(key_valid), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_mode_i(in_mode), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data));
  tea_iter_core #(.ROUNDS(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .key_wr_i(key_wr), .key_hi_i(key_hi), .key_in_i(key_in),
    .key_ready_o(kr4), .key_valid_o(kv4), .in_valid_i(v4),
    .in_ready_o(ir4), .in_mode_i(in_mode), .in_data_i(in_data),
    .out_valid_o(ov4), .out_ready_i(1'b1), .out_data_o(od4));
  tea_iter_core #(.ROUNDS(8), .UNROLL(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .key_wr_i(key_wr), .key_hi_i(key_hi), .key_in_i(key_in),
    .key_ready_o(kr8), .key_valid_o(kv8), .in_valid_i(v8),
    .in_ready_o(ir8), .in_mode_i(in_mode), .in_data_i(in_data),
    .out_valid_o(ov8), .out_ready_i(1'b1), .out_data_o(od8));
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  function automatic logic [63:0] tea_ref(input logic [63:0] v, input logic [127:0] k,
                                          input bit dec, input int n);
    logic [31:0] a, b, s, k0, k1, k2, k3;
    {a, b} = v;
    {k0, k1, k2, k3} = k;
    s = dec ? 32'(n) * DELTA : 32'h0;
    for (int i = 0; i < n; i++) begin
      if (!dec) begin
        s += DELTA;
        a += ((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1);
        b += ((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3);
      end else begin
        b -= ((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3);
        a -= ((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1);
        s -= DELTA;
      end
    end
    return {a, b};
  endfunction
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_main got=%h exp=none", out_data);
      end else chk("sb_main", out_data, q.pop_front());
    end
  always @(negedge clk)
    if (rst_n && ov4) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_u4 got=%h exp=none", od4);
      end else chk("sb_u4", od4, q4.pop_front());
    end
  always @(negedge clk)
    if (rst_n && ov8) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_r8 got=%h exp=none", od8);
      end else chk("sb_r8", od8, q8.pop_front());
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wkey(input bit hi, input logic [63:0] v);
    key_wr = 1;
    key_hi = hi;
    key_in = v;
    step();
    key_wr = 0;
  endtask
  task automatic send(input bit m, input logic [63:0] d, input logic [63:0] e);
    int t = 0;
    while (!in_ready && t < 300) begin
      step();
      t++;
    end
    if (!in_ready) begin
      chk("accept_wait", {63'b0, in_ready}, 64'd1);
      return;
    end
    in_valid = 1;
    in_mode  = m;
    in_data  = d;
    q.push_back(e);
    step();
    in_valid = 0;
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_valid || !key_ready) && t < 500) begin
      step();
      t++;
    end
    chk("drain", {63'b0, t < 500}, 64'd1);
  endtask
  initial begin
    int l1 = 0, l4 = 0, l8 = 0, t;
    logic [127:0] k;
    logic [63:0] p, e;
    step();
    step();
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_key_valid", {63'b0, key_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_key_ready", {63'b0, key_ready}, 64'd1);
    rst_n = 1;
    step();
    wkey(1, 64'd0);
    @(negedge clk);
    chk("half_key_valid", {63'b0, key_valid}, 64'd0);
    chk("half_in_ready", {63'b0, in_ready}, 64'd0);
    step();
    in_valid = 1;
    in_mode  = 0;
    in_data  = 64'd0;
    step();
    step();
    @(negedge clk);
    chk("no_accept_nokey", {63'b0, key_ready}, 64'd1);
    step();
    key_wr = 1;
    key_hi = 0;
    key_in = 64'd0;
    step();
    key_wr = 0;
    v4 = 1;
    v8 = 1;
    q.push_back(T1);
    q4.push_back(T1);
    q8.push_back(tea_ref(64'd0, 128'd0, 0, 8));
    @(negedge clk);
    chk("no_accept_same_edge", {63'b0, key_ready}, 64'd1);
    chk("ready_after_key", {63'b0, in_ready}, 64'd1);
    step();
    in_valid = 0;
    v4 = 0;
    v8 = 0;
    for (int c = 1; c <= 60 && l1 == 0; c++) begin
      @(negedge clk);
      if (out_valid && l1 == 0) l1 = c;
      if (ov4 && l4 == 0) l4 = c;
      if (ov8 && l8 == 0) l8 = c;
    end
    chk("lat_main", 64'(l1), 64'd33);
    chk("lat_u4", 64'(l4), 64'd9);
    chk("lat_r8", 64'(l8), 64'd3);
    drain();
    send(1, T1, 64'd0);
    drain();
    key_wr   = 1;
    key_hi   = 1;
    key_in   = KX;
    in_valid = 1;
    in_mode  = 0;
    in_data  = 64'd0;
    q.push_back(T1);
    step();
    key_wr   = 0;
    in_valid = 0;
    @(negedge clk);
    chk("kv_after_rewrite", {63'b0, key_valid}, 64'd1);
    drain();
    send(0, 64'd0, tea_ref(64'd0, {KX, 64'd0}, 0, 32));
    drain();
    for (int i = 0; i < 100; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom};
      e = tea_ref(p, k, 0, 32);
      wkey(1, k[127:64]);
      wkey(0, k[63:0]);
      send(0, p, e);
      send(1, e, p);
      drain();
    end
    wkey(1, 64'd0);
    wkey(0, 64'd0);
    out_ready = 0;
    send(0, 64'd0, T1);
    t = 0;
    while (!out_valid && t < 100) begin
      step();
      t++;
    end
    chk("done_wait", {63'b0, out_valid}, 64'd1);
    in_valid = 1;
    in_mode  = 0;
    in_data  = Y;
    q.push_back(tea_ref(Y, 128'd0, 0, 32));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_data", out_data, T1);
      chk("hold_in_ready", {63'b0, in_ready}, 64'd0);
      step();
    end
    out_ready = 1;
    step();
    @(negedge clk);
    chk("ready_after_release", {63'b0, in_ready}, 64'd1);
    step();
    in_valid = 0;
    @(negedge clk);
    chk("accepted_next", {63'b0, key_ready}, 64'd0);
    drain();
    send(0, 64'd0, T1);
    repeat (5) step();
    wkey(1, KX);
    drain();
    send(0, 64'd0, T1);
    drain();
    in_valid = 1;
    in_data  = 64'd0;
    step();
    in_valid = 0;
    repeat (5) step();
    #2 rst_n = 0;
    #1;
    chk("rst_run_key_valid", {63'b0, key_valid}, 64'd0);
    chk("rst_run_idle", {63'b0, key_ready}, 64'd1);
    step();
    rst_n = 1;
    step();
    wkey(1, 64'd0);
    wkey(0, 64'd0);
    out_ready = 0;
    in_valid  = 1;
    step();
    in_valid = 0;
    t = 0;
    while (!out_valid && t < 100) begin
      step();
      t++;
    end
    chk("done_wait2", {63'b0, out_valid}, 64'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_done_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_done_key_valid", {63'b0, key_valid}, 64'd0);
    chk("rst_done_out_data", out_data, 64'd0);
    step();
    rst_n = 1;
    out_ready = 1;
    step();
    chk("sb_left_main", 64'(q.size()), 64'd0);
    chk("sb_left_u4", 64'(q4.size()), 64'd0);
    chk("sb_left_r8", 64'(q8.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
